// File: rtl/wb_axis_bridge_pkg.sv
// Shared constants for the Wishbone <-> AXI-Stream bridge: register offsets,
// STATUS bit positions and the handshake FSM encoding.
package wb_axis_bridge_pkg;

  // Word offsets, i.e. wbs_adr_i[7:2]
  localparam logic [5:0] ADR_X_IN   = 6'h20;  // 0x80
  localparam logic [5:0] ADR_Y_OUT  = 6'h21;  // 0x84
  localparam logic [5:0] ADR_STATUS = 6'h22;  // 0x88
  localparam logic [5:0] ADR_X_LAST = 6'h23;  // 0x8C

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TIMEOUT  = 4;
  localparam int ST_RX_LAST  = 5;
  localparam int ST_TX_LVL   = 8;
  localparam int ST_RX_LVL   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_axis_bridge_fifo.sv
// Small synchronous FIFO with a combinational head view, so a push is visible
// at the output in the very next cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wb_axis_bridge.sv
// Wishbone slave feeding the FIR stream input from a TX FIFO and draining its
// output into an RX FIFO; a stall FSM bounds how long an ack can be withheld.
module wb_axis_bridge
  import wb_axis_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_MAX  = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [7:0]        wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              ss_tvalid,
  output logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tlast,
  input  logic              ss_tready,
  input  logic              sm_tvalid,
  input  logic [DATA_W-1:0] sm_tdata,
  input  logic              sm_tlast,
  output logic              sm_tready
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(STALL_MAX + 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ack;
  logic [DATA_W-1:0]  r_dat;
  logic               r_timeout;
  logic               r_rx_last;

  logic [DATA_W:0]    w_tx_head, w_rx_head;
  logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [LVL_W-1:0]   w_tx_level, w_rx_level;
  logic [7:0]         w_tx_lvl8, w_rx_lvl8;
  logic [5:0]         w_adr;
  logic               w_req, w_is_xw, w_is_yr, w_is_st_rd, w_is_st_wr, w_svc;
  logic               w_act, w_tmo, w_cnt_clr, w_cnt_inc;
  logic [DATA_W-1:0]  w_status;
  logic               w_unused_ok;

  assign w_adr      = wbs_adr_i[7:2];
  assign w_req      = wbs_cyc_i & wbs_stb_i;
  assign w_is_xw    = wbs_we_i & ((w_adr == ADR_X_IN) | (w_adr == ADR_X_LAST));
  assign w_is_yr    = ~wbs_we_i & (w_adr == ADR_Y_OUT);
  assign w_is_st_rd = ~wbs_we_i & (w_adr == ADR_STATUS);
  assign w_is_st_wr = wbs_we_i & (w_adr == ADR_STATUS);
  assign w_svc      = w_is_xw ? ~w_tx_full : (w_is_yr ? ~w_rx_empty : 1'b1);

  sync_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(wb_clk_i), .i_srst(wb_rst_i),
    .i_push(w_act & w_is_xw),
    .i_push_data({(w_adr == ADR_X_LAST), wbs_dat_i}),
    .i_pop(ss_tready), .o_head(w_tx_head),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
  );

  sync_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(wb_clk_i), .i_srst(wb_rst_i),
    .i_push(sm_tvalid), .i_push_data({sm_tlast, sm_tdata}),
    .i_pop(w_act & w_is_yr), .o_head(w_rx_head),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
  );

  assign ss_tvalid = ~w_tx_empty;
  assign ss_tdata  = w_tx_head[DATA_W-1:0];
  assign ss_tlast  = w_tx_head[DATA_W];
  assign sm_tready = ~w_rx_full;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  assign w_tx_lvl8 = 8'(w_tx_level);
  assign w_rx_lvl8 = 8'(w_rx_level);

  always_comb begin
    w_status                    = '0;
    w_status[ST_TX_FULL]        = w_tx_full;
    w_status[ST_TX_EMPTY]       = w_tx_empty;
    w_status[ST_RX_FULL]        = w_rx_full;
    w_status[ST_RX_EMPTY]       = w_rx_empty;
    w_status[ST_TIMEOUT]        = r_timeout;
    w_status[ST_RX_LAST]        = r_rx_last;
    w_status[ST_TX_LVL +: 4]    = w_tx_lvl8[3:0];
    w_status[ST_RX_LVL +: 4]    = w_rx_lvl8[3:0];
  end

  always_comb begin
    w_state_next = r_state;
    w_act        = 1'b0;
    w_tmo        = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_svc) begin
            w_act        = 1'b1;
            w_state_next = S_ACK;
          end else begin
            w_cnt_clr    = 1'b1;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A master that withdraws the cycle gets neither action nor ack
        if (!w_req) begin
          w_state_next = S_IDLE;
        end else if (w_svc) begin
          w_act        = 1'b1;
          w_state_next = S_ACK;
        end else if (r_cnt == CNT_W'(STALL_MAX)) begin
          w_tmo        = 1'b1;
          w_state_next = S_ACK;
        end else begin
          w_cnt_inc    = 1'b1;
        end
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_timeout <= 1'b0;
      r_rx_last <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= (w_state_next == S_ACK);
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_act) begin
        if (w_is_yr) begin
          r_dat <= w_rx_head[DATA_W-1:0];
          if (w_rx_head[DATA_W]) r_rx_last <= 1'b1;
        end else if (w_is_st_rd) begin
          r_dat <= w_status;
        end else begin
          r_dat <= '0;
        end
        if (w_is_st_wr) begin
          if (wbs_dat_i[ST_TIMEOUT]) r_timeout <= 1'b0;
          if (wbs_dat_i[ST_RX_LAST]) r_rx_last <= 1'b0;
        end
      end
      if (w_tmo) begin
        r_timeout <= 1'b1;
        r_dat     <= wbs_we_i ? '0 : '1;
      end
    end
  end

  assign w_unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], w_tx_lvl8[7:4], w_rx_lvl8[7:4]};

endmodule

// File: tb/tb_wb_axis_bridge.sv
// Directed bench for wb_axis_bridge: Wishbone accesses, stream handshakes,
// stall/timeout behaviour and reset during a stalled access.
module tb_wb_axis_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [7:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        ss_tvalid, ss_tlast, ss_tready = 1'b0;
  logic [31:0] ss_tdata;
  logic        sm_tvalid = 1'b0, sm_tlast = 1'b0, sm_tready;
  logic [31:0] sm_tdata = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  int          lat;
  logic        cap_v, cap_l;
  logic [31:0] cap_d;

  always #5 clk = ~clk;

  wb_axis_bridge #(.DATA_W(32), .FIFO_DEPTH(4), .STALL_MAX(15)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  // Starts in cycle N (#1 after an edge); n = cycles from N to the ack cycle, -1 if none.
  task automatic wb_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] r, output int n);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = -1; r = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        cap_v = ss_tvalid; cap_d = ss_tdata; cap_l = ss_tlast;
      end
      if (ack) begin
        n = k; r = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("wb we=%0d adr=%h wdat=%h rdat=%h lat=%0d", w, a, d, r, n);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", rdat); end
    checks++; if (ss_tvalid !== 1'b0) begin errors++; $display("FAIL rst_ss_tvalid got %b exp 0", ss_tvalid); end
    checks++; if (sm_tready !== 1'b1) begin errors++; $display("FAIL rst_sm_tready got %b exp 1", sm_tready); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_status_lat got %0d exp 1", lat); end
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL rst_status got %h exp 0000000a", rd); end
  endtask

  task automatic test_single_write();
    ss_tready = 1'b1;
    wb_access(1'b1, 8'h80, 32'h5, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat got %0d exp 1", lat); end
    checks++; if ({cap_v, cap_l, cap_d} !== {1'b1, 1'b0, 32'h5})
      begin errors++; $display("FAIL wr_ss got v=%b l=%b d=%h exp v=1 l=0 d=00000005", cap_v, cap_l, cap_d); end
    checks++; if (ss_tvalid !== 1'b0) begin errors++; $display("FAIL wr_popped got %b exp 0", ss_tvalid); end
    ss_tready = 1'b0;
  endtask

  task automatic test_fill_stall();
    ss_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_access(1'b1, 8'h80, 32'(i), rd, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL fill_lat%0d got %0d exp 1", i, lat); end
    end
    fork
      wb_access(1'b1, 8'h80, 32'h5, rd, lat);
      begin
        repeat (10) @(posedge clk);
        #1 ss_tready = 1'b1;
        @(posedge clk);
        #1 ss_tready = 1'b0;
      end
    join
    checks++; if (lat !== 12) begin errors++; $display("FAIL stall_lat got %0d exp 12", lat); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_0409) begin errors++; $display("FAIL fill_status got %h exp 00000409", rd); end
    checks++; if (ss_tdata !== 32'h2) begin errors++; $display("FAIL fill_head got %h exp 00000002", ss_tdata); end
    ss_tready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checks++; if ({ss_tvalid, ss_tdata} !== {1'b1, 32'(i)})
        begin errors++; $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h", i, ss_tvalid, ss_tdata, 32'(i)); end
      @(posedge clk); #1;
    end
    checks++; if (ss_tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", ss_tvalid); end
    ss_tready = 1'b0;
  endtask

  task automatic test_last_and_rx();
    wb_access(1'b1, 8'h8C, 32'hA, rd, lat);
    checks++; if ({cap_v, cap_l, cap_d} !== {1'b1, 1'b1, 32'hA})
      begin errors++; $display("FAIL xlast_ss got v=%b l=%b d=%h exp v=1 l=1 d=0000000a", cap_v, cap_l, cap_d); end
    ss_tready = 1'b1;
    @(posedge clk);
    #1 ss_tready = 1'b0;
    sm_tvalid = 1'b1; sm_tdata = 32'h37; sm_tlast = 1'b1;
    @(posedge clk);
    #1 sm_tvalid = 1'b0; sm_tlast = 1'b0;
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0001_0002) begin errors++; $display("FAIL rx_status got %h exp 00010002", rd); end
    wb_access(1'b0, 8'h84, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h37) begin errors++; $display("FAIL y_read got %h lat %0d exp 00000037 lat 1", rd, lat); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_002A) begin errors++; $display("FAIL rx_last_set got %h exp 0000002a", rd); end
    wb_access(1'b1, 8'h88, 32'h20, rd, lat);
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL rx_last_w1c got %h exp 0000000a", rd); end
    wb_access(1'b0, 8'h80, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL xin_read got %h lat %0d exp 0 lat 1", rd, lat); end
  endtask

  task automatic test_timeout();
    wb_access(1'b0, 8'h84, 32'h0, rd, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL tmo_lat got %0d exp 17", lat); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_dat got %h exp ffffffff", rd); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_001A) begin errors++; $display("FAIL tmo_status got %h exp 0000001a", rd); end
    wb_access(1'b1, 8'h88, 32'h10, rd, lat);
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL tmo_w1c got %h exp 0000000a", rd); end
  endtask

  task automatic test_late_beat();
    fork
      wb_access(1'b0, 8'h84, 32'h0, rd, lat);
      begin
        repeat (3) @(posedge clk);
        #1 sm_tvalid = 1'b1; sm_tdata = 32'h12;
        @(posedge clk);
        #1 sm_tvalid = 1'b0;
      end
    join
    checks++; if (lat !== 5) begin errors++; $display("FAIL late_lat got %0d exp 5", lat); end
    checks++; if (rd !== 32'h12) begin errors++; $display("FAIL late_dat got %h exp 00000012", rd); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL late_status got %h exp 0000000a", rd); end
  endtask

  task automatic test_reset_mid_wait();
    int acks = 0;
    ss_tready = 1'b0;
    wb_access(1'b1, 8'h80, 32'h11, rd, lat);
    wb_access(1'b1, 8'h80, 32'h22, rd, lat);
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_0208) begin errors++; $display("FAIL pre_rst_status got %h exp 00000208", rd); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h84;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ss_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_ss_tvalid got %b exp 0", ss_tvalid); end
    repeat (5) begin
      if (ack) acks++;
      @(posedge clk); #1;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL mid_rst_ack got %0d acks exp 0", acks); end
    wb_access(1'b0, 8'h88, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL mid_rst_status got %h exp 0000000a", rd); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_stall();
    test_last_and_rx();
    test_timeout();
    test_late_beat();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
